// File: rtl/uart_tx_frame_ctrl_if.sv
// Host-side signal bundle for the UART TX frame controller.
// The master drives request and config signals; the slave returns line and status.
interface uart_tx_frame_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  bit_tick;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_valid;
    logic                  Par_en;
    logic                  Par_typ;
    logic                  Stop_two;
    logic                  TX_OUT;
    logic                  Busy;
    logic                  tx_done;

    modport master (
        output bit_tick, P_DATA, Data_valid, Par_en, Par_typ, Stop_two,
        input  TX_OUT, Busy, tx_done
    );

    modport slave (
        input  bit_tick, P_DATA, Data_valid, Par_en, Par_typ, Stop_two,
        output TX_OUT, Busy, tx_done
    );
endinterface

// File: rtl/uart_tx_frame_ctrl.sv
// UART transmit frame controller: FSM, serializer, parity and line mux in one block.
// All outputs are registered from next-state values, so none of them has an input-to-output path.
module uart_tx_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int CNT_W      = $clog2(DATA_WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    uart_tx_frame_ctrl_if.slave tx_if
);
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        STR  = 3'd1,
        DATA = 3'd2,
        PAR  = 3'd3,
        STP  = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    state_t                r_state, w_state_nxt;
    logic [DATA_WIDTH-1:0] r_shift, w_shift_nxt;
    logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
    logic                  r_stp_cnt, w_stp_cnt_nxt;
    logic                  r_par_en, w_par_en_nxt;
    logic                  r_par_bit, w_par_bit_nxt;
    logic                  r_stop_two, w_stop_two_nxt;
    logic                  r_tx, w_tx_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  w_accept;

    always_comb begin
        w_state_nxt    = r_state;
        w_shift_nxt    = r_shift;
        w_cnt_nxt      = r_cnt;
        w_stp_cnt_nxt  = r_stp_cnt;
        w_par_en_nxt   = r_par_en;
        w_par_bit_nxt  = r_par_bit;
        w_stop_two_nxt = r_stop_two;
        w_done_nxt     = 1'b0;
        w_accept       = 1'b0;

        case (r_state)
            IDLE: w_accept = tx_if.Data_valid;
            STR: begin
                if (tx_if.bit_tick) begin
                    w_state_nxt = DATA;
                    w_cnt_nxt   = '0;
                end
            end
            DATA: begin
                if (tx_if.bit_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_cnt == LAST_BIT) begin
                        w_state_nxt   = r_par_en ? PAR : STP;
                        w_stp_cnt_nxt = 1'b0;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tx_if.bit_tick) begin
                    w_state_nxt   = STP;
                    w_stp_cnt_nxt = 1'b0;
                end
            end
            STP: begin
                if (tx_if.bit_tick) begin
                    if (r_stop_two && !r_stp_cnt) begin
                        w_stp_cnt_nxt = 1'b1;
                    end else begin
                        // Frame ends here; a pending request chains straight into STR.
                        w_done_nxt  = 1'b1;
                        w_accept    = tx_if.Data_valid;
                        w_state_nxt = IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt   = IDLE;
                w_shift_nxt   = '0;
                w_cnt_nxt     = '0;
                w_stp_cnt_nxt = 1'b0;
            end
        endcase

        if (w_accept) begin
            w_state_nxt    = STR;
            w_shift_nxt    = tx_if.P_DATA;
            w_par_en_nxt   = tx_if.Par_en;
            w_par_bit_nxt  = (^tx_if.P_DATA) ^ tx_if.Par_typ;
            w_stop_two_nxt = tx_if.Stop_two;
            w_stp_cnt_nxt  = 1'b0;
        end

        case (w_state_nxt)
            STR:     w_tx_nxt = 1'b0;
            DATA:    w_tx_nxt = w_shift_nxt[0];
            PAR:     w_tx_nxt = w_par_bit_nxt;
            default: w_tx_nxt = 1'b1;
        endcase
        w_busy_nxt = (w_state_nxt != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_shift    <= '0;
            r_cnt      <= '0;
            r_stp_cnt  <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_two <= 1'b0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_shift    <= w_shift_nxt;
            r_cnt      <= w_cnt_nxt;
            r_stp_cnt  <= w_stp_cnt_nxt;
            r_par_en   <= w_par_en_nxt;
            r_par_bit  <= w_par_bit_nxt;
            r_stop_two <= w_stop_two_nxt;
            r_tx       <= w_tx_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
        end
    end

    assign tx_if.TX_OUT  = r_tx;
    assign tx_if.Busy    = r_busy;
    assign tx_if.tx_done = r_done;
endmodule

// File: tb/tb_uart_tx_frame_ctrl.sv
// Bench for uart_tx_frame_ctrl: directed frames plus randomized traffic against a
// frame-as-bit-list reference model, checked every cycle on the falling edge.
module tb_uart_tx_frame_ctrl;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_tx_frame_ctrl_if #(.DATA_WIDTH(DW)) bus ();
    uart_tx_frame_ctrl_if #(.DATA_WIDTH(5))  bus5 ();

    uart_tx_frame_ctrl #(.DATA_WIDTH(DW)) dut (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus)
    );

    uart_tx_frame_ctrl #(.DATA_WIDTH(5)) dut5 (
        .clk   (clk),
        .rst   (rst),
        .tx_if (bus5)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: a frame is just the list of line levels, one per tick.
    logic m_bits[$];
    int   m_idx  = 0;
    bit   m_busy = 1'b0;
    bit   m_done = 1'b0;

    function automatic void m_load(input logic [DW-1:0] d, input bit pe, input bit pt, input bit s2);
        m_bits.delete();
        m_bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) m_bits.push_back(d[i]);
        if (pe) m_bits.push_back(^d ^ pt);
        m_bits.push_back(1'b1);
        if (s2) m_bits.push_back(1'b1);
        m_idx  = 0;
        m_busy = 1'b1;
    endfunction

    always @(posedge clk) begin
        m_done = 1'b0;
        if (!rst) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (bus.Data_valid) m_load(bus.P_DATA, bus.Par_en, bus.Par_typ, bus.Stop_two);
        end else if (bus.bit_tick) begin
            m_idx++;
            if (m_idx == m_bits.size()) begin
                m_done = 1'b1;
                if (bus.Data_valid) m_load(bus.P_DATA, bus.Par_en, bus.Par_typ, bus.Stop_two);
                else m_busy = 1'b0;
            end
        end
    end

    function automatic logic m_tx();
        return m_busy ? m_bits[m_idx] : 1'b1;
    endfunction

    task automatic run_cycle();
        @(negedge clk);
        check("tx_out",  {31'd0, bus.TX_OUT},  {31'd0, m_tx()});
        check("busy",    {31'd0, bus.Busy},    {31'd0, m_busy});
        check("tx_done", {31'd0, bus.tx_done}, {31'd0, m_done});
    endtask

    task automatic set_in(input bit v, input bit t, input logic [DW-1:0] d,
                          input bit pe, input bit pt, input bit s2);
        bus.Data_valid = v;
        bus.bit_tick   = t;
        bus.P_DATA     = d;
        bus.Par_en     = pe;
        bus.Par_typ    = pt;
        bus.Stop_two   = s2;
    endtask

    int exp_a5[11] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 0, 1};
    int exp_00[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
    int exp_5w[7]  = '{0, 1, 1, 0, 0, 1, 1};
    int dones;
    int mode;
    int cyc;

    initial begin
        rst = 1'b0;
        set_in(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
        bus5.Data_valid = 1'b0;
        bus5.bit_tick   = 1'b0;
        bus5.P_DATA     = '0;
        bus5.Par_en     = 1'b0;
        bus5.Par_typ    = 1'b0;
        bus5.Stop_two   = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_tx",   {31'd0, bus.TX_OUT},  32'd1);
        check("rst_busy", {31'd0, bus.Busy},    32'd0);
        check("rst_done", {31'd0, bus.tx_done}, 32'd0);
        rst = 1'b1;
        run_cycle();

        // 0xA5, even parity, one stop bit
        set_in(1'b1, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 11; i++) begin
            run_cycle();
            bus.Data_valid = 1'b0;
            check("a5_bit",  {31'd0, bus.TX_OUT}, exp_a5[i]);
            check("a5_busy", {31'd0, bus.Busy},   32'd1);
        end
        run_cycle();
        check("a5_end_busy", {31'd0, bus.Busy},    32'd0);
        check("a5_end_done", {31'd0, bus.tx_done}, 32'd1);

        // 0x00, odd parity, two stop bits
        set_in(1'b1, 1'b1, 8'h00, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            run_cycle();
            bus.Data_valid = 1'b0;
            check("z_bit",  {31'd0, bus.TX_OUT}, exp_00[i]);
            check("z_busy", {31'd0, bus.Busy},   32'd1);
        end
        run_cycle();
        check("z_end_done", {31'd0, bus.tx_done}, 32'd1);

        // Back-to-back: valid held, data changes mid-frame
        set_in(1'b1, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        dones = 0;
        for (int i = 0; i < 21; i++) begin
            run_cycle();
            if (i == 4) bus.P_DATA = 8'hFF;
            if (i == 10) bus.Data_valid = 1'b0;
            if (i < 20) check("b2b_busy", {31'd0, bus.Busy}, 32'd1);
            if (bus.tx_done) dones++;
        end
        check("b2b_dones", dones, 32'd2);

        // Reset during the 4th data bit aborts the frame
        set_in(1'b1, 1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            run_cycle();
            bus.Data_valid = 1'b0;
        end
        rst = 1'b0;
        run_cycle();
        rst = 1'b1;
        check("abort_tx",   {31'd0, bus.TX_OUT},  32'd1);
        check("abort_busy", {31'd0, bus.Busy},    32'd0);
        check("abort_done", {31'd0, bus.tx_done}, 32'd0);
        for (int i = 0; i < 3; i++) run_cycle();

        // Randomized traffic: tick always, every 4th cycle, or random
        cyc = 0;
        for (int seg = 0; seg < 6; seg++) begin
            mode = seg % 3;
            for (int i = 0; i < 600; i++) begin
                cyc++;
                bus.Data_valid = ($urandom_range(0, 3) == 0);
                bus.P_DATA     = DW'($urandom);
                bus.Par_en     = 1'($urandom);
                bus.Par_typ    = 1'($urandom);
                bus.Stop_two   = 1'($urandom);
                case (mode)
                    0:       bus.bit_tick = 1'b1;
                    1:       bus.bit_tick = (cyc % 4 == 0);
                    default: bus.bit_tick = 1'($urandom);
                endcase
                rst = ($urandom_range(0, 399) != 0);
                run_cycle();
            end
        end
        rst = 1'b1;
        set_in(1'b0, 1'b1, '0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 15; i++) run_cycle();

        // DATA_WIDTH=5 instance: 5'b10011, no parity, one stop bit
        bus5.bit_tick   = 1'b1;
        bus5.P_DATA     = 5'b10011;
        bus5.Data_valid = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            bus5.Data_valid = 1'b0;
            check("w5_bit",  {31'd0, bus5.TX_OUT}, exp_5w[i]);
            check("w5_busy", {31'd0, bus5.Busy},   32'd1);
        end
        @(negedge clk);
        check("w5_end_busy", {31'd0, bus5.Busy},    32'd0);
        check("w5_end_done", {31'd0, bus5.tx_done}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
